peripheral_pwm: RTL and testbench

//  Multi-channel PWM generator on the J1 I/O bus, instantiated in j1soc next to mult/div/uart.

---
 rtl/peripheral_pwm.sv | 186 ++++++++++++++++++
 tb/tb_peripheral_pwm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_pwm.sv
// Multi-channel PWM peripheral on the J1 I/O bus with double-buffered period/duty registers.
// Optional interrupt output is enabled by defining PWM_IRQ_EN.
module peripheral_pwm #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    d_in,
  input  logic           cs,
  input  logic [3:0]     addr,
  input  logic           rd,
  input  logic           wr,
  output logic [15:0]    d_out,
  output logic [NCH-1:0] pwm_out
`ifdef PWM_IRQ_EN
  ,
  output logic           irq
`endif
);

  typedef enum logic [3:0] {
    A_CTRL   = 4'd0,
    A_PRESC  = 4'd1,
    A_PERIOD = 4'd2,
    A_STATUS = 4'd3,
    A_DUTY0  = 4'd4,
    A_DUTY1  = 4'd5,
    A_DUTY2  = 4'd6,
    A_DUTY3  = 4'd7,
    A_COUNT  = 4'd8
  } reg_addr_e;

  logic           en;
  logic [NCH-1:0] pol;
  logic [CW-1:0]  presc;
  logic [CW-1:0]  pcnt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  period_sh;
  logic [CW-1:0]  period_act;
  logic [CW-1:0]  duty_sh  [NCH];
  logic [CW-1:0]  duty_act [NCH];
  logic           wrap;
`ifdef PWM_IRQ_EN
  logic           ie;
`endif

  logic           wr_en;
  logic           rd_en;
  logic           tick;
  logic           at_end;
  logic           wrap_set;
  logic           status_rd;
  logic [NCH-1:0] duty_wr;
  logic [15:0]    rdata;

  assign wr_en     = cs & wr;
  assign rd_en     = cs & rd;
  // >= rather than == so a PRESC lowered below the running pcnt still ticks
  assign tick      = en && (pcnt >= presc);
  assign at_end    = (cnt == period_act);
  assign wrap_set  = tick & at_end;
  assign status_rd = rd_en && (addr == A_STATUS);

  always_comb begin
    duty_wr = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      duty_wr[i] = wr_en && (addr == 4'(32'(A_DUTY0) + i));
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL: begin
        rdata[0]       = en;
`ifdef PWM_IRQ_EN
        rdata[1]       = ie;
`endif
        rdata[4 +: NCH] = pol;
      end
      A_PRESC:  rdata[CW-1:0] = presc;
      A_PERIOD: rdata[CW-1:0] = period_sh;
      A_STATUS: rdata[0]      = wrap;
      A_COUNT:  rdata[CW-1:0] = cnt;
      default: begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (addr == 4'(32'(A_DUTY0) + i)) rdata[CW-1:0] = duty_sh[i];
        end
      end
    endcase
  end

  // Bus-visible control and shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      pol       <= '0;
      presc     <= '0;
      period_sh <= '0;
      for (int unsigned i = 0; i < NCH; i++) duty_sh[i] <= '0;
`ifdef PWM_IRQ_EN
      ie        <= 1'b0;
`endif
    end else begin
      if (wr_en && (addr == A_CTRL)) begin
        en  <= d_in[0];
        pol <= d_in[4 +: NCH];
`ifdef PWM_IRQ_EN
        ie  <= d_in[1];
`endif
      end
      if (wr_en && (addr == A_PRESC))  presc     <= d_in[CW-1:0];
      if (wr_en && (addr == A_PERIOD)) period_sh <= d_in[CW-1:0];
      for (int unsigned i = 0; i < NCH; i++) begin
        if (duty_wr[i]) duty_sh[i] <= d_in[CW-1:0];
      end
    end
  end

  // Prescaler, period counter and shadow->active transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      cnt        <= '0;
      period_act <= '0;
      for (int unsigned i = 0; i < NCH; i++) duty_act[i] <= '0;
    end else if (!en) begin
      pcnt       <= '0;
      cnt        <= '0;
      period_act <= period_sh;
      for (int unsigned i = 0; i < NCH; i++) duty_act[i] <= duty_sh[i];
    end else if (tick) begin
      pcnt <= '0;
      if (at_end) begin
        cnt        <= '0;
        period_act <= period_sh;
        for (int unsigned i = 0; i < NCH; i++) duty_act[i] <= duty_sh[i];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      pcnt <= pcnt + CW'(1);
    end
  end

  // A wrap landing on the same edge as a STATUS read wins over the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else if (wrap_set) begin
      wrap <= 1'b1;
    end else if (status_rd) begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
    end else if (rd_en) begin
      d_out <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        pwm_out[i] <= (en & (cnt < duty_act[i])) ^ pol[i];
      end
    end
  end

`ifdef PWM_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= wrap & ie;
    end
  end
`endif

endmodule

// File: tb/tb_peripheral_pwm.sv
// Self-checking bench for peripheral_pwm: time-based reference model plus directed scenarios.
// Build with PWM_IRQ_EN defined to also exercise the interrupt output.
module tb_peripheral_pwm;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [15:0]    d_in = '0;
  logic           cs = 1'b0;
  logic [3:0]     addr = '0;
  logic           rd = 1'b0;
  logic           wr = 1'b0;
  logic [15:0]    d_out;
  logic [NCH-1:0] pwm_out;
`ifdef PWM_IRQ_EN
  logic           irq;
`endif

  always #5 clk = ~clk;

  peripheral_pwm #(.NCH(NCH), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .cs      (cs),
    .addr    (addr),
    .rd      (rd),
    .wr      (wr),
    .d_out   (d_out),
    .pwm_out (pwm_out)
`ifdef PWM_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the counter value is derived from elapsed cycles since enable,
  // with the period start advanced by whole periods whenever the tick count overruns it.
  int         cyc = 0;
  bit         m_en, m_ie, m_wrap, m_irq;
  logic [3:0] m_pol, m_pwm;
  logic [15:0] m_dout;
  int         m_presc, m_per_sh, m_per_act, m_cnt, m_base, m_en_cyc;
  int         m_duty_sh[4];
  int         m_duty_act[4];

  function automatic logic [15:0] model_read(input logic [3:0] a);
    logic [15:0] v;
    v = '0;
    case (a)
      4'd0: v = {8'h00, m_pol, 2'b00, m_ie, m_en};
      4'd1: v = 16'(m_presc);
      4'd2: v = 16'(m_per_sh);
      4'd3: v = {15'd0, m_wrap};
      4'd4, 4'd5, 4'd6, 4'd7: v = 16'(m_duty_sh[int'(a) - 4]);
      4'd8: v = 16'(m_cnt);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [3:0]  pwm_n;
    logic [15:0] dout_n;
    bit          irq_n, set;
    int          t;
    cyc++;
    if (rst) begin
      m_en = 0; m_ie = 0; m_wrap = 0; m_irq = 0; m_pol = '0; m_pwm = '0; m_dout = '0;
      m_presc = 0; m_per_sh = 0; m_per_act = 0; m_cnt = 0; m_base = 0; m_en_cyc = 0;
      for (int i = 0; i < 4; i++) begin m_duty_sh[i] = 0; m_duty_act[i] = 0; end
      return;
    end
    for (int i = 0; i < 4; i++) pwm_n[i] = (m_en && (m_cnt < m_duty_act[i])) ^ m_pol[i];
    irq_n  = m_wrap & m_ie;
    dout_n = (cs && rd) ? model_read(addr) : m_dout;
    set = 0;
    if (!m_en) begin
      m_cnt = 0; m_base = 0; m_per_act = m_per_sh;
      for (int i = 0; i < 4; i++) m_duty_act[i] = m_duty_sh[i];
    end else begin
      t = (cyc - m_en_cyc) / (m_presc + 1);
      if (t - m_base > m_per_act) begin
        set = 1;
        m_base += m_per_act + 1;
        m_per_act = m_per_sh;
        for (int i = 0; i < 4; i++) m_duty_act[i] = m_duty_sh[i];
      end
      m_cnt = t - m_base;
    end
    if (set) m_wrap = 1;
    else if (cs && rd && addr == 4'd3) m_wrap = 0;
    if (cs && wr) begin
      case (addr)
        4'd0: begin
          if (!m_en && d_in[0]) m_en_cyc = cyc;
          m_en  = d_in[0];
          m_pol = d_in[7:4];
`ifdef PWM_IRQ_EN
          m_ie  = d_in[1];
`endif
        end
        4'd1: m_presc  = int'(d_in);
        4'd2: m_per_sh = int'(d_in);
        4'd4, 4'd5, 4'd6, 4'd7: m_duty_sh[int'(addr) - 4] = int'(d_in);
        default: ;
      endcase
    end
    m_pwm = pwm_n; m_dout = dout_n; m_irq = irq_n;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("pwm_out", 16'(pwm_out), 16'(m_pwm));
      chk("d_out", d_out, m_dout);
`ifdef PWM_IRQ_EN
      chk("irq", 16'(irq), 16'(m_irq));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    cs = 1; wr = 1; addr = a; d_in = d;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
    cs = 1; rd = 1; addr = a;
    @(negedge clk);
    cs = 0; rd = 0;
    v = d_out;
  endtask

  task automatic wait_cnt(input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("wait_cnt timeout", 16'(m_cnt), 16'(target));
  endtask

  logic [15:0] v;
  int          hi, idx, r1, r2;
  bit          ok1, ok2;
  logic        bits [30];

  initial begin
    // T1 reset
    repeat (2) @(negedge clk);
    rst = 0;
    chk_on = 1;
    chk("reset pwm_out", 16'(pwm_out), 16'h0000);
    chk("reset d_out", d_out, 16'h0000);
    rd_reg(4'd8, v); chk("reset COUNT", v, 16'h0000);
    rd_reg(4'd3, v); chk("reset STATUS", v, 16'h0000);

    // T2 basic 3/10 duty
    wr_reg(4'd1, 16'd0);
    wr_reg(4'd2, 16'd9);
    wr_reg(4'd4, 16'd3);
    wr_reg(4'd0, 16'h0001);
    repeat (12) @(negedge clk);
    hi = 0;
    repeat (10) begin @(negedge clk); hi += int'(pwm_out[0]); end
    chk("T2 duty0 highs per 10", 16'(hi), 16'd3);
    wait_cnt(4);
    rd_reg(4'd3, v); chk("T2 STATUS first", v, 16'h0001);
    rd_reg(4'd3, v); chk("T2 STATUS second", v, 16'h0000);

    // T3 shadow update mid-pulse
    wait_cnt(1);
    bits[0] = pwm_out[0];
    wr_reg(4'd4, 16'd7);
    for (int k = 1; k < 30; k++) begin
      bits[k] = pwm_out[0];
      @(negedge clk);
    end
    idx = 0; r1 = 0; r2 = 0;
    while (idx < 30 && bits[idx]) begin r1++; idx++; end
    while (idx < 30 && !bits[idx]) idx++;
    while (idx < 30 && bits[idx]) begin r2++; idx++; end
    chk("T3 old pulse len", 16'(r1), 16'd3);
    chk("T3 new pulse len", 16'(r2), 16'd7);

    // T4 edge duties and polarity
    wr_reg(4'd5, 16'd0);
    wr_reg(4'd6, 16'd10);
    repeat (25) @(negedge clk);
    ok1 = 1; ok2 = 1;
    repeat (20) begin
      if (pwm_out[1] !== 1'b0) ok1 = 0;
      if (pwm_out[2] !== 1'b1) ok2 = 0;
      @(negedge clk);
    end
    chk("T4 duty1=0 const low", 16'(ok1), 16'd1);
    chk("T4 duty2>period const high", 16'(ok2), 16'd1);
    wr_reg(4'd0, 16'h0041);
    repeat (2) @(negedge clk);
    ok2 = 1;
    repeat (20) begin
      if (pwm_out[2] !== 1'b0) ok2 = 0;
      @(negedge clk);
    end
    chk("T4 pol2 const low", 16'(ok2), 16'd1);

    // T5 prescaler
    wr_reg(4'd0, 16'h0000);
    wr_reg(4'd1, 16'd4);
    wr_reg(4'd2, 16'd3);
    wr_reg(4'd7, 16'd2);
    wr_reg(4'd0, 16'h0001);
    for (int k = 1; k <= 21; k++) begin
      rd_reg(4'd8, v);
      chk("T5 COUNT step", v, 16'(((k - 1) / 5) % 4));
    end
    hi = 0;
    repeat (20) begin @(negedge clk); hi += int'(pwm_out[3]); end
    chk("T5 duty3 highs per 20", 16'(hi), 16'd10);

`ifdef PWM_IRQ_EN
    // Interrupt on wrap
    wr_reg(4'd0, 16'h0000);
    wr_reg(4'd1, 16'd0);
    wr_reg(4'd2, 16'd9);
    wr_reg(4'd0, 16'h0003);
    rd_reg(4'd0, v); chk("IRQ CTRL readback", v, 16'h0003);
    idx = 0;
    while (irq !== 1'b1 && idx < 40) begin @(negedge clk); idx++; end
    chk("IRQ rise", 16'(irq), 16'h0001);
    rd_reg(4'd3, v); chk("IRQ STATUS", v, 16'h0001);
    @(negedge clk);
    chk("IRQ clear", 16'(irq), 16'h0000);
`else
    wr_reg(4'd0, 16'h0003);
    rd_reg(4'd0, v); chk("CTRL b1 ignored", v, 16'h0001);
`endif

    // T6 reset mid-period
    wr_reg(4'd0, 16'h0000);
    wr_reg(4'd1, 16'd0);
    wr_reg(4'd2, 16'd9);
    wr_reg(4'd0, 16'h00F1);
    wait_cnt(5);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("T6 pwm_out after rst", 16'(pwm_out), 16'h0000);
    for (int a = 0; a <= 8; a++) begin
      rd_reg(4'(a), v);
      chk("T6 reg after rst", v, 16'h0000);
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
